mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: ADDR_W, 6, word-address width; internal data memory holds 2**ADDR_W 32-bit words.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 valid_i  input  1  an instruction from EX/MEM is present this cycle.
REQ-005 mem_read_i  input  1  load request.
REQ-006 mem_write_i  input  1  store request.
REQ-007 addr_i  input  32  byte address (ALU result).
REQ-008 wdata_i  input  32  store data.
REQ-009 reg_dest_i  input  5  writeback register number.
REQ-010 reg_write_i  input  1  writeback enable.
REQ-011 mem_to_reg_i  input  1  writeback selects memory data.
REQ-012 stall_o  output  1  upstream shall hold its inputs at the next edge.
REQ-013 valid_o  output  1  outputs carry a completed instruction this cycle.
REQ-014 read_data_o  output  32  load data (to MEM/WB dat1).
REQ-015 alu_result_o  output  32  registered addr_i (to MEM/WB dat2).
REQ-016 reg_dest_o  output  5, reg_write_o  output  1, mem_to_reg_o  output  1  registered sideband.
REQ-017 err_o  output  1  one-cycle pulse marking a faulted access.

Function
REQ-018 The word index shall be addr_i[ADDR_W+1:2]; higher address bits are ignored, so addresses wrap modulo the memory size.
REQ-019 An access is faulted when (mem_read_i|mem_write_i) & addr_i[1:0]!=0, or when mem_read_i & mem_write_i are both set.
REQ-020 The FSM shall have two states, IDLE and RD_WAIT, and shall reset to IDLE.
REQ-021 IDLE, valid_i=0: valid_o<=0 and reg_write_o<=0 at the edge; all other outputs hold.
REQ-022 IDLE, valid_i=1, non-read or faulted: complete at the next edge E0 -- valid_o<=1; sideband and alu_result_o registered; read_data_o<=0; stall_o=0.
REQ-023 Store (aligned, not faulted): the memory word is written at E0.
REQ-024 Faulted access: no memory write; err_o<=1 and reg_write_o<=0 at E0; valid_o<=1.
REQ-025 Aligned load in IDLE: stall_o=1 combinationally in that cycle; at E0 the index and sideband are latched and the state moves to RD_WAIT; valid_o<=0.
REQ-026 RD_WAIT: stall_o=0; all inputs are ignored (upstream still presents the held load); at E1, read_data_o<=mem[latched index], valid_o<=1, latched sideband drives the outputs, and the state returns to IDLE.
REQ-027 Load latency shall be 2 edges; every other instruction completes in 1 edge; back-to-back loads cost 2 cycles each.
REQ-028 A load immediately following a store to the same word shall return the newly stored data.
REQ-029 err_o and valid_o shall each be high for exactly one cycle per instruction.
REQ-030 Whenever valid_o=0, reg_write_o shall be 0.

Reset
REQ-031 While reset=1: state IDLE; valid_o, err_o, reg_write_o, mem_to_reg_o, read_data_o, alu_result_o, reg_dest_o all 0; stall_o forced 0.
REQ-032 Reset asserted in RD_WAIT shall drop the pending load with no output.
REQ-033 Memory contents are not cleared by reset.

Verification
REQ-034 Store 0xDEADBEEF to 0x10, then load 0x10 with reg_dest 5 -> store: valid_o one cycle later with reg_write_o as driven; load: stall_o=1 for one cycle, then read_data_o=0xDEADBEEF, reg_dest_o=5, valid_o=1 two edges after acceptance.
REQ-035 With ADDR_W=6, store 0x11111111 to 0x000, then load 0x100 -> read_data_o=0x11111111 (wrap).
REQ-036 Load from 0x13 with reg_write_i=1 -> err_o=1, reg_write_o=0, no stall, read_data_o=0; memory unchanged.
REQ-037 mem_read_i=mem_write_i=1 at 0x20 holding 0x5 -> err_o=1, word at 0x20 still 0x5.
REQ-038 Assert reset in RD_WAIT -> valid_o stays 0, all outputs 0, state IDLE; a subsequent load of a previously stored word returns the stored value.
REQ-039 ALU-only op (addr_i=0x1234, reg_dest 9, reg_write 1), then a bubble -> alu_result_o=0x1234, valid_o=1 for one cycle; in the bubble cycle, reg_write_o=0.

Source files
------------

// File: rtl/mem_stage.sv
// Memory stage: word-addressed data memory behind a two-state load FSM.
// Loads take two edges (stall upstream one cycle), everything else takes one.
// Misaligned accesses and read+write requests are faulted and pulse err_o.
module mem_stage #(
  parameter int ADDR_W = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  reg_dest_i,
  input  logic        reg_write_i,
  input  logic        mem_to_reg_i,
  output logic        stall_o,
  output logic        valid_o,
  output logic [31:0] read_data_o,
  output logic [31:0] alu_result_o,
  output logic [4:0]  reg_dest_o,
  output logic        reg_write_o,
  output logic        mem_to_reg_o,
  output logic        err_o
);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  // Pending load captured at acceptance; drives the outputs at completion.
  typedef struct packed {
    logic [ADDR_W-1:0] idx;
    logic [31:0]       addr;
    logic [4:0]        dest;
    logic              rw;
    logic              m2r;
  } ld_t;

  state_t            state;
  ld_t               ld;
  logic [31:0]       mem [2**ADDR_W];
  logic [ADDR_W-1:0] idx;
  logic              fault;
  logic              load_ok;
  logic              store_ok;

  // Upper address bits are dropped, so the memory aliases modulo its size.
  assign idx      = addr_i[ADDR_W+1:2];
  assign fault    = ((mem_read_i | mem_write_i) & (addr_i[1:0] != 2'b00)) |
                    (mem_read_i & mem_write_i);
  assign load_ok  = valid_i & mem_read_i & ~fault;
  assign store_ok = valid_i & mem_write_i & ~fault & (state == IDLE) & ~reset;
  assign stall_o  = ~reset & (state == IDLE) & load_ok;

  // Data memory: no reset, contents survive reset.
  always_ff @(posedge clk) begin
    if (store_ok) mem[idx] <= wdata_i;
  end

  // Load FSM and registered outputs; valid/err/reg_write default low each edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      ld           <= '0;
      valid_o      <= 1'b0;
      err_o        <= 1'b0;
      reg_write_o  <= 1'b0;
      mem_to_reg_o <= 1'b0;
      read_data_o  <= '0;
      alu_result_o <= '0;
      reg_dest_o   <= '0;
    end else begin
      valid_o     <= 1'b0;
      err_o       <= 1'b0;
      reg_write_o <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_i) begin
            if (load_ok) begin
              ld    <= '{idx: idx, addr: addr_i, dest: reg_dest_i,
                         rw: reg_write_i, m2r: mem_to_reg_i};
              state <= RD_WAIT;
            end else begin
              valid_o      <= 1'b1;
              err_o        <= fault;
              reg_write_o  <= reg_write_i & ~fault;
              reg_dest_o   <= reg_dest_i;
              mem_to_reg_o <= mem_to_reg_i;
              alu_result_o <= addr_i;
              read_data_o  <= '0;
            end
          end
        end
        RD_WAIT: begin
          valid_o      <= 1'b1;
          read_data_o  <= mem[ld.idx];
          alu_result_o <= ld.addr;
          reg_dest_o   <= ld.dest;
          reg_write_o  <= ld.rw;
          mem_to_reg_o <= ld.m2r;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: transaction-level model (word array + queue of
// expected completions tagged with their cycle) checked every negedge,
// plus literal checks for the directed scenarios.
module tb_mem_stage;
  localparam int ADDR_W = 6;
  localparam int WORDS  = 1 << ADDR_W;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_i = 1'b0, mem_read_i = 1'b0, mem_write_i = 1'b0;
  logic [31:0] addr_i = '0, wdata_i = '0;
  logic [4:0]  reg_dest_i = '0;
  logic        reg_write_i = 1'b0, mem_to_reg_i = 1'b0;
  logic        stall_o, valid_o, reg_write_o, mem_to_reg_o, err_o;
  logic [31:0] read_data_o, alu_result_o;
  logic [4:0]  reg_dest_o;

  mem_stage #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .mem_read_i(mem_read_i),
    .mem_write_i(mem_write_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .reg_dest_i(reg_dest_i), .reg_write_i(reg_write_i),
    .mem_to_reg_i(mem_to_reg_i), .stall_o(stall_o), .valid_o(valid_o),
    .read_data_o(read_data_o), .alu_result_o(alu_result_o),
    .reg_dest_o(reg_dest_o), .reg_write_o(reg_write_o),
    .mem_to_reg_o(mem_to_reg_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic [31:0] alu;
    logic [4:0]  dest;
    logic        rw;
    logic        m2r;
    logic        err;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mem_m [WORDS];
  int          cyc = 0;
  int          tests = 0, fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Present one instruction at a negedge; returns at the negedge where its
  // completion is visible on the outputs.
  task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] dest,
                       input logic rw, input logic m2r);
    exp_t e;
    logic flt, is_ld;
    int   w;
    flt   = ((rd | wr) && addr[1:0] != 2'b00) || (rd && wr);
    is_ld = rd && !flt;
    w     = int'(addr[ADDR_W+1:2]);
    valid_i = 1'b1; mem_read_i = rd; mem_write_i = wr; addr_i = addr;
    wdata_i = wd; reg_dest_i = dest; reg_write_i = rw; mem_to_reg_i = m2r;
    e.cyc  = cyc + (is_ld ? 2 : 1);
    e.data = is_ld ? mem_m[w] : 32'h0;
    e.alu  = addr;
    e.dest = dest;
    e.rw   = flt ? 1'b0 : rw;
    e.m2r  = m2r;
    e.err  = flt;
    q.push_back(e);
    if (wr && !flt) mem_m[w] = wd;
    #1 chk("stall_accept", {31'b0, stall_o}, {31'b0, is_ld});
    @(negedge clk);
    if (is_ld) begin
      #1 chk("stall_rdwait", {31'b0, stall_o}, 32'h0);
      @(negedge clk);
    end
  endtask

  task automatic bubble();
    valid_i = 1'b0; mem_read_i = 1'($urandom); mem_write_i = 1'($urandom);
    addr_i = $urandom; wdata_i = $urandom; reg_dest_i = 5'($urandom);
    reg_write_i = 1'b1; mem_to_reg_i = 1'($urandom);
    @(negedge clk);
  endtask

  // Compare process: every negedge, outputs against the expected-completion queue.
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_valid", {31'b0, valid_o}, 32'h0);
      chk("rst_err", {31'b0, err_o}, 32'h0);
      chk("rst_rw", {31'b0, reg_write_o}, 32'h0);
      chk("rst_m2r", {31'b0, mem_to_reg_o}, 32'h0);
      chk("rst_rdata", read_data_o, 32'h0);
      chk("rst_alu", alu_result_o, 32'h0);
      chk("rst_dest", {27'b0, reg_dest_o}, 32'h0);
      chk("rst_stall", {31'b0, stall_o}, 32'h0);
    end else begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        tests++; fails++;
        $display("FAIL missed_completion: expected at cycle %0d, now %0d", q[0].cyc, cyc);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        chk("valid", {31'b0, valid_o}, 32'h1);
        chk("rdata", read_data_o, q[0].data);
        chk("alu", alu_result_o, q[0].alu);
        chk("dest", {27'b0, reg_dest_o}, {27'b0, q[0].dest});
        chk("rw", {31'b0, reg_write_o}, {31'b0, q[0].rw});
        chk("m2r", {31'b0, mem_to_reg_o}, {31'b0, q[0].m2r});
        chk("err", {31'b0, err_o}, {31'b0, q[0].err});
        void'(q.pop_front());
      end else begin
        chk("idle_valid", {31'b0, valid_o}, 32'h0);
        chk("idle_rw", {31'b0, reg_write_o}, 32'h0);
        chk("idle_err", {31'b0, err_o}, 32'h0);
      end
    end
  end

  initial begin
    logic [31:0] a;
    int          kind;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Fill every word so later random loads have defined expectations.
    for (int w = 0; w < WORDS; w++) begin
      a = $urandom; a[ADDR_W+1:0] = {w[ADDR_W-1:0], 2'b00};
      issue(1'b0, 1'b1, a, $urandom, 5'($urandom), 1'($urandom), 1'($urandom));
    end

    // Store then load of the same word, with literal expectations.
    issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 5'd3, 1'b0, 1'b0);
    chk("st_valid", {31'b0, valid_o}, 32'h1);
    chk("st_rw", {31'b0, reg_write_o}, 32'h0);
    issue(1'b1, 1'b0, 32'h10, 32'h0, 5'd5, 1'b1, 1'b1);
    chk("ld_rdata", read_data_o, 32'hDEADBEEF);
    chk("ld_dest", {27'b0, reg_dest_o}, 32'd5);
    chk("ld_valid", {31'b0, valid_o}, 32'h1);

    // Address wrap.
    issue(1'b0, 1'b1, 32'h000, 32'h11111111, 5'd1, 1'b0, 1'b0);
    issue(1'b1, 1'b0, 32'h100, 32'h0, 5'd2, 1'b1, 1'b1);
    chk("wrap_rdata", read_data_o, 32'h11111111);

    // Misaligned load.
    issue(1'b1, 1'b0, 32'h13, 32'h0, 5'd4, 1'b1, 1'b1);
    chk("mis_err", {31'b0, err_o}, 32'h1);
    chk("mis_rw", {31'b0, reg_write_o}, 32'h0);
    chk("mis_rdata", read_data_o, 32'h0);
    issue(1'b1, 1'b0, 32'h10, 32'h0, 5'd6, 1'b1, 1'b0);
    chk("mis_unchanged", read_data_o, 32'hDEADBEEF);

    // Read+write together: faulted, no write.
    issue(1'b0, 1'b1, 32'h20, 32'h5, 5'd0, 1'b0, 1'b0);
    issue(1'b1, 1'b1, 32'h20, 32'hFFFF0000, 5'd8, 1'b1, 1'b0);
    chk("rw_err", {31'b0, err_o}, 32'h1);
    issue(1'b1, 1'b0, 32'h20, 32'h0, 5'd8, 1'b1, 1'b1);
    chk("rw_unchanged", read_data_o, 32'h5);

    // Reset while a load is in RD_WAIT: dropped with no output.
    issue(1'b0, 1'b1, 32'h30, 32'hCAFE0001, 5'd0, 1'b0, 1'b0);
    valid_i = 1'b1; mem_read_i = 1'b1; mem_write_i = 1'b0; addr_i = 32'h30;
    reg_dest_i = 5'd7; reg_write_i = 1'b1; mem_to_reg_i = 1'b1;
    #1 chk("rst_ld_stall", {31'b0, stall_o}, 32'h1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("rst_mid_valid", {31'b0, valid_o}, 32'h0);
    chk("rst_mid_dest", {27'b0, reg_dest_o}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    bubble();
    chk("rst_after_valid", {31'b0, valid_o}, 32'h0);
    issue(1'b1, 1'b0, 32'h30, 32'h0, 5'd7, 1'b1, 1'b1);
    chk("rst_mem_kept", read_data_o, 32'hCAFE0001);

    // ALU-only op then a bubble.
    issue(1'b0, 1'b0, 32'h1234, 32'h0, 5'd9, 1'b1, 1'b0);
    chk("alu_result", alu_result_o, 32'h1234);
    chk("alu_valid", {31'b0, valid_o}, 32'h1);
    chk("alu_rw", {31'b0, reg_write_o}, 32'h1);
    bubble();
    chk("bub_valid", {31'b0, valid_o}, 32'h0);
    chk("bub_rw", {31'b0, reg_write_o}, 32'h0);

    // Randomized mix.
    for (int i = 0; i < 300; i++) begin
      kind = int'($urandom_range(0, 9));
      a = $urandom;
      case (kind)
        0, 1: bubble();
        2, 3: issue(1'b0, 1'b0, a, $urandom, 5'($urandom), 1'($urandom), 1'($urandom));
        4, 5: begin
          a[1:0] = 2'b00;
          issue(1'b0, 1'b1, a, $urandom, 5'($urandom), 1'($urandom), 1'($urandom));
        end
        6, 7, 8: begin
          a[1:0] = 2'b00;
          issue(1'b1, 1'b0, a, $urandom, 5'($urandom), 1'($urandom), 1'($urandom));
        end
        default: begin
          if ($urandom_range(0, 1) == 0) begin
            if (a[1:0] == 2'b00) a[0] = 1'b1;
            issue(1'($urandom), 1'b1, a, $urandom, 5'($urandom), 1'($urandom), 1'($urandom));
          end else begin
            issue(1'b1, 1'b1, a, $urandom, 5'($urandom), 1'($urandom), 1'($urandom));
          end
        end
      endcase
    end

    repeat (4) bubble();
    chk("queue_drained", q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
